sload_arbiter: RTL and testbench
================================

Name: sload_arbiter

Overview:
- Shares the single scratchpad DRAM load port (sLoad / load_addr / sLoad_hit / load_data) among the four bank access FSMs.
- Replaces the fixed-priority load_addr mux with round-robin arbitration.
- Holds one outstanding load at a time and routes returned data to the granted bank.
- Sits between the bank access FSMs and the scratchpad top-level load interface.

Parameters:
NUM_REQ, 4, number of requesting bank access FSMs
ADDR_W, 32, load address width
DATA_W, 64, load data width
TIMEOUT_CYC, 256, cycles in BUSY without sLoad_hit before abort (optional feature only)

Ports:
CLK  in  1  clock
RST  in  1  reset, asynchronous, active-high
req_valid  in  NUM_REQ  per-bank load request, level, held until rsp_valid
req_addr  in  NUM_REQ*ADDR_W  per-bank address, slice i = bits [i*ADDR_W +: ADDR_W]
grant  out  NUM_REQ  one-hot, requester currently owning the port
sLoad  out  1  load request to memory side
load_addr  out  ADDR_W  latched address of granted requester
sLoad_hit  in  1  memory side: load_data valid this cycle
load_data  in  DATA_W  returned data
rsp_valid  out  NUM_REQ  one-cycle pulse to the served requester
rsp_data  out  DATA_W  registered load data, valid with rsp_valid
busy  out  1  high when state != IDLE
timeout_err  out  1  one-cycle pulse on abort; constant 0 without the macro

Behaviour:
- Reset (RST high, asynchronous) forces:
  - state=IDLE, rr_ptr=0, mask=0.
  - All outputs 0: grant, sLoad, load_addr, rsp_valid, rsp_data, busy, timeout_err.
  - Applies in any state; an in-flight load is dropped and no response is delivered.
- States: IDLE, BUSY, RESP.
- IDLE:
  - eligible = req_valid & ~mask.
  - If eligible != 0, pick the first set bit scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - Register grant one-hot and idx, latch load_addr=req_addr[idx], go to BUSY.
  - mask clears to 0 after every IDLE cycle.
- Latency: req_valid high in IDLE at cycle N -> grant, sLoad, busy high at N+1.
- BUSY:
  - sLoad=1; load_addr is stable for the whole state.
  - Changes on req_addr or req_valid are ignored; there is no cancellation.
  - On sLoad_hit: rsp_data<=load_data, go to RESP.
- RESP (exactly one cycle):
  - rsp_valid[idx]=1; grant stays set; sLoad=0.
  - Next state is IDLE, with rr_ptr<=(idx+1) mod NUM_REQ (wraps 3->0) and mask<=grant.
  - The mask keeps the served requester, whose req_valid is still high for one cycle, from being re-granted.
- Requester rule: drop req_valid in the cycle after rsp_valid, or keep it high to issue a new request (re-arbitrated after the mask cycle).
- sLoad_hit in IDLE or RESP: ignored, no rsp_valid.
- Back-to-back throughput: minimum 4 cycles per load (IDLE, BUSY with hit, RESP, masked IDLE only when the sole requester is the one just served). Otherwise 3 cycles.
- grant and rsp_valid are always one-hot or zero; at most one outstanding load.

Optional Feature:
- Macro: SLOAD_ARB_TIMEOUT_EN.
- Defined:
  - An 8..16-bit wait counter clears on entry to BUSY and increments each BUSY cycle without sLoad_hit.
  - When the counter reaches TIMEOUT_CYC-1 with no hit, go to RESP with rsp_data=0 and timeout_err=1 for that cycle. rsp_valid[idx] still pulses so the requester unblocks; rr_ptr and mask update normally.
  - A hit in the same cycle as the limit wins: normal response, no error.
- Not defined: no counter; BUSY waits indefinitely; timeout_err tied 0.

Test Plan:
1. After reset, req_valid=0100, req_addr[2]=0x100; sLoad_hit 3 cycles after sLoad with load_data=0xDEAD -> grant=0100, sLoad and load_addr=0x100 one cycle after request; rsp_valid=0100, rsp_data=0xDEAD one cycle after hit; busy low the cycle after RESP.
2. After reset, req_valid=1111 held, each served requester drops req after rsp, hit 1 cycle after each sLoad -> grant order 0001,0010,0100,1000; no overlap.
3. req0 kept asserted continuously, req2 steady -> grants alternate 0,2,0,2; req0 never granted in the masked cycle after its own RESP.
4. sLoad_hit pulsed in IDLE and in RESP -> no rsp_valid, state unchanged; req_addr changed mid-BUSY -> load_addr unchanged.
5. RST asserted mid-BUSY for bank 3 -> all outputs 0 immediately (asynchronous); after release, req_valid=1001 -> bank 0 granted first.
6. With SLOAD_ARB_TIMEOUT_EN and TIMEOUT_CYC=16, no hit -> sLoad high 16 cycles, then rsp_valid with rsp_data=0 and timeout_err one-cycle pulse. Hit on cycle 16 -> normal response, timeout_err=0.

Source files
------------

// File: rtl/sload_arbiter.sv
// Round-robin owner of the scratchpad load port for NUM_REQ bank FSMs; optional BUSY abort via SLOAD_ARB_TIMEOUT_EN.
// Latency: grant/sLoad/busy one cycle after req_valid in IDLE; rsp_valid/rsp_data one cycle after sLoad_hit.
// Backpressure: one load in flight; losers keep req_valid high and are re-arbitrated after the owner's RESP.
module sload_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 64
`ifdef SLOAD_ARB_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 256
`endif
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      sLoad,
  output logic [ADDR_W-1:0]         load_addr,
  input  logic                      sLoad_hit,
  input  logic [DATA_W-1:0]         load_data,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      busy,
  output logic                      timeout_err
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [NUM_REQ-1:0]  r_grant;
  logic [NUM_REQ-1:0]  r_mask;
  logic [IW-1:0]       r_idx;
  logic [IW-1:0]       r_rr_ptr;
  logic [ADDR_W-1:0]   r_load_addr;
  logic [DATA_W-1:0]   r_rsp_data;

  logic [NUM_REQ-1:0]  w_elig;
  logic [NUM_REQ-1:0]  w_pick_oh;
  logic [IW-1:0]       w_pick_idx;
  logic [IW-1:0]       w_rr_next;
  logic [IW:0]         w_sum;
  logic                w_found;
  logic                w_expire;

  // The requester just served is masked for exactly one IDLE cycle.
  assign w_elig    = req_valid & ~r_mask;
  assign w_pick_oh = NUM_REQ'(1) << w_pick_idx;
  assign w_rr_next = (r_idx == IW'(NUM_REQ - 1)) ? '0 : r_idx + 1'b1;

  // Round-robin scan starting at rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    w_found    = 1'b0;
    w_pick_idx = '0;
    w_sum      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_sum = {1'b0, r_rr_ptr} + (IW+1)'(i);
      if (w_sum >= (IW+1)'(NUM_REQ)) w_sum = w_sum - (IW+1)'(NUM_REQ);
      if (!w_found && w_elig[w_sum[IW-1:0]]) begin
        w_found    = 1'b1;
        w_pick_idx = w_sum[IW-1:0];
      end
    end
  end

`ifdef SLOAD_ARB_TIMEOUT_EN
  logic [15:0] r_wait_cnt;
  logic        r_timeout;

  assign w_expire = (r_state == S_BUSY) && !sLoad_hit &&
                    (r_wait_cnt == 16'(TIMEOUT_CYC - 1));

  // Wait counter: cleared on BUSY entry, counts BUSY cycles without a hit; error flag follows the abort into RESP.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_wait_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_timeout <= w_expire;
      if (r_state == S_IDLE && w_found) r_wait_cnt <= '0;
      else if (r_state == S_BUSY && !sLoad_hit) r_wait_cnt <= r_wait_cnt + 16'd1;
    end
  end

  assign timeout_err = r_timeout;
`else
  assign w_expire    = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state: IDLE grants, BUSY waits for hit (or abort), RESP lasts one cycle.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_found) w_next = S_BUSY;
      S_BUSY:  if (sLoad_hit || w_expire) w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: latch owner and address on grant, capture data on hit, advance pointer and mask on RESP.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_grant     <= '0;
      r_mask      <= '0;
      r_idx       <= '0;
      r_rr_ptr    <= '0;
      r_load_addr <= '0;
      r_rsp_data  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_mask <= '0;
          if (w_found) begin
            r_grant     <= w_pick_oh;
            r_idx       <= w_pick_idx;
            r_load_addr <= req_addr[w_pick_idx*ADDR_W +: ADDR_W];
          end
        end
        S_BUSY: begin
          if (sLoad_hit)     r_rsp_data <= load_data;
          else if (w_expire) r_rsp_data <= '0;
        end
        S_RESP: begin
          r_grant  <= '0;
          r_mask   <= r_grant;
          r_rr_ptr <= w_rr_next;
        end
        default: r_grant <= '0;
      endcase
    end
  end

  assign grant     = r_grant;
  assign sLoad     = (r_state == S_BUSY);
  assign busy      = (r_state != S_IDLE);
  assign load_addr = r_load_addr;
  assign rsp_data  = r_rsp_data;
  assign rsp_valid = (r_state == S_RESP) ? r_grant : '0;

endmodule

// File: tb/tb_sload_arbiter.sv
// Bench for sload_arbiter: expected responses queued when sLoad_hit is driven, compared when rsp_valid appears.
// Latency: inputs driven and outputs sampled 1ns after each rising CLK edge.
// Backpressure: every wait on the DUT is bounded by a cycle budget.
module tb_sload_arbiter;

  logic         CLK;
  logic         RST;
  logic [3:0]   req_valid;
  logic [127:0] req_addr;
  logic [3:0]   grant;
  logic         sLoad;
  logic [31:0]  load_addr;
  logic         sLoad_hit;
  logic [63:0]  load_data;
  logic [3:0]   rsp_valid;
  logic [63:0]  rsp_data;
  logic         busy;
  logic         timeout_err;

  typedef struct packed {
    logic [3:0]  bank;
    logic [63:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks   = 0;
  int   failures = 0;
  int   cyc;

  sload_arbiter #(
    .NUM_REQ(4), .ADDR_W(32), .DATA_W(64)
`ifdef SLOAD_ARB_TIMEOUT_EN
    , .TIMEOUT_CYC(16)
`endif
  ) dut (
    .CLK(CLK), .RST(RST), .req_valid(req_valid), .req_addr(req_addr),
    .grant(grant), .sLoad(sLoad), .load_addr(load_addr),
    .sLoad_hit(sLoad_hit), .load_data(load_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
    .timeout_err(timeout_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_grant(input int max, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (grant == 4'b0 && n < max);
  endtask

  task automatic do_reset();
    req_valid = '0;
    req_addr  = '0;
    sLoad_hit = 1'b0;
    load_data = '0;
    RST       = 1'b1;
    #3;
    RST = 1'b0;
    sb.delete();
    tick();
  endtask

  task automatic test_reset();
    req_valid = '0; req_addr = '0; sLoad_hit = 1'b0; load_data = '0;
    RST = 1'b1;
    #7;
    checks++;
    if ({grant, sLoad, rsp_valid, busy, timeout_err} !== 11'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got=%b exp=0", {grant, sLoad, rsp_valid, busy, timeout_err});
    end
    checks++;
    if ({load_addr, rsp_data} !== 96'b0) begin
      failures++;
      $display("FAIL reset_data: load_addr=%h rsp_data=%h exp=0", load_addr, rsp_data);
    end
    @(negedge CLK);
    RST = 1'b0;
    tick();
  endtask

  task automatic test_single();
    do_reset();
    req_valid = 4'b0100;
    req_addr[64 +: 32] = 32'h100;
    tick();
    checks++;
    if ({grant, sLoad, busy} !== {4'b0100, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL single_grant: grant=%b sLoad=%b busy=%b exp 0100 1 1", grant, sLoad, busy);
    end
    checks++;
    if (load_addr !== 32'h100) begin
      failures++;
      $display("FAIL single_addr: got=%h exp=100", load_addr);
    end
    tick();
    tick();
    sLoad_hit = 1'b1; load_data = 64'hDEAD;
    sb.push_back('{4'b0100, 64'hDEAD});
    tick();
    sLoad_hit = 1'b0;
    checks++;
    if (sb.size() == 0) begin
      failures++; $display("FAIL single_rsp: scoreboard empty");
    end else begin
      e = sb.pop_front();
      if ({rsp_valid, rsp_data} !== {e.bank, e.data}) begin
        failures++;
        $display("FAIL single_rsp: got=%b/%h exp=%b/%h", rsp_valid, rsp_data, e.bank, e.data);
      end
    end
    checks++;
    if ({grant, sLoad} !== {4'b0100, 1'b0}) begin
      failures++;
      $display("FAIL single_resp_state: grant=%b sLoad=%b exp 0100 0", grant, sLoad);
    end
    req_valid = '0;
    tick();
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL single_idle: busy=%b exp 0", busy);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < 4; i++) req_addr[i*32 +: 32] = 32'h1000 + 32'(i * 16);
    req_valid = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      wait_grant(20, cyc);
      checks++;
      if ({grant, load_addr} !== {4'(1 << k), 32'h1000 + 32'(k * 16)}) begin
        failures++;
        $display("FAIL rr_grant%0d: grant=%b addr=%h exp=%b", k, grant, load_addr, 4'(1 << k));
      end
      checks++;
      if (cyc !== ((k == 0) ? 1 : 2)) begin
        failures++;
        $display("FAIL rr_gap%0d: cycles=%0d exp=%0d", k, cyc, (k == 0) ? 1 : 2);
      end
      sLoad_hit = 1'b1; load_data = 64'hA0 + 64'(k);
      sb.push_back('{4'(1 << k), 64'hA0 + 64'(k)});
      tick();
      sLoad_hit = 1'b0;
      checks++;
      if (sb.size() == 0) begin
        failures++; $display("FAIL rr_rsp%0d: scoreboard empty", k);
      end else begin
        e = sb.pop_front();
        if ({rsp_valid, rsp_data} !== {e.bank, e.data}) begin
          failures++;
          $display("FAIL rr_rsp%0d: got=%b/%h exp=%b/%h", k, rsp_valid, rsp_data, e.bank, e.data);
        end
      end
      req_valid[k] = 1'b0;
    end
    tick();
  endtask

  task automatic test_back_to_back();
    do_reset();
    req_addr[0 +: 32]  = 32'h200;
    req_addr[64 +: 32] = 32'h220;
    req_valid = 4'b0101;
    for (int k = 0; k < 5; k++) begin
      if (k == 4) req_valid = 4'b0001;
      wait_grant(20, cyc);
      checks++;
      if (grant !== ((k % 2 == 0) ? 4'b0001 : 4'b0100)) begin
        failures++;
        $display("FAIL alt_grant%0d: got=%b exp=%b", k, grant, (k % 2 == 0) ? 4'b0001 : 4'b0100);
      end
      sLoad_hit = 1'b1; load_data = 64'hB0 + 64'(k);
      sb.push_back('{grant, 64'hB0 + 64'(k)});
      tick();
      sLoad_hit = 1'b0;
      checks++;
      if (sb.size() == 0) begin
        failures++; $display("FAIL alt_rsp%0d: scoreboard empty", k);
      end else begin
        e = sb.pop_front();
        if ({rsp_valid, rsp_data} !== {e.bank, e.data}) begin
          failures++;
          $display("FAIL alt_rsp%0d: got=%b/%h exp=%b/%h", k, rsp_valid, rsp_data, e.bank, e.data);
        end
      end
    end
    // Sole requester bank 0 still high: one masked IDLE cycle before its next grant.
    wait_grant(20, cyc);
    checks++;
    if ({grant, 32'(cyc)} !== {4'b0001, 32'd3}) begin
      failures++;
      $display("FAIL mask_gap: grant=%b cycles=%0d exp 0001 3", grant, cyc);
    end
    sLoad_hit = 1'b1; load_data = 64'hBEEF;
    tick();
    sLoad_hit = 1'b0;
    req_valid = '0;
    tick();
  endtask

  task automatic test_ignore();
    do_reset();
    sLoad_hit = 1'b1; load_data = 64'h1111;
    tick();
    tick();
    sLoad_hit = 1'b0;
    checks++;
    if ({rsp_valid, busy, rsp_data} !== 69'b0) begin
      failures++;
      $display("FAIL idle_hit: rsp_valid=%b busy=%b rsp_data=%h exp 0", rsp_valid, busy, rsp_data);
    end
    req_valid = 4'b0010;
    req_addr[32 +: 32] = 32'h300;
    wait_grant(20, cyc);
    req_addr[32 +: 32] = 32'h999;
    req_valid = '0;
    tick();
    tick();
    checks++;
    if ({grant, sLoad, load_addr} !== {4'b0010, 1'b1, 32'h300}) begin
      failures++;
      $display("FAIL busy_stable: grant=%b sLoad=%b addr=%h exp 0010 1 300", grant, sLoad, load_addr);
    end
    sLoad_hit = 1'b1; load_data = 64'hC0DE;
    sb.push_back('{4'b0010, 64'hC0DE});
    tick();
    load_data = 64'h5555;
    checks++;
    if (sb.size() == 0) begin
      failures++; $display("FAIL ign_rsp: scoreboard empty");
    end else begin
      e = sb.pop_front();
      if ({rsp_valid, rsp_data} !== {e.bank, e.data}) begin
        failures++;
        $display("FAIL ign_rsp: got=%b/%h exp=%b/%h", rsp_valid, rsp_data, e.bank, e.data);
      end
    end
    tick();
    sLoad_hit = 1'b0;
    checks++;
    if ({rsp_valid, busy, rsp_data} !== {4'b0, 1'b0, 64'hC0DE}) begin
      failures++;
      $display("FAIL resp_hit: rsp_valid=%b busy=%b rsp_data=%h exp 0 0 c0de", rsp_valid, busy, rsp_data);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    req_valid = 4'b1000;
    req_addr[96 +: 32] = 32'h400;
    req_addr[0 +: 32]  = 32'h40;
    wait_grant(20, cyc);
    tick();
    #3;
    RST = 1'b1;
    #1;
    checks++;
    if ({grant, sLoad, rsp_valid, busy, timeout_err, load_addr, rsp_data} !== 107'b0) begin
      failures++;
      $display("FAIL async_reset: grant=%b sLoad=%b busy=%b addr=%h exp all 0", grant, sLoad, busy, load_addr);
    end
    #2;
    RST = 1'b0;
    req_valid = 4'b1001;
    wait_grant(20, cyc);
    checks++;
    if ({grant, load_addr, 32'(cyc)} !== {4'b0001, 32'h40, 32'd1}) begin
      failures++;
      $display("FAIL post_reset_grant: grant=%b addr=%h cycles=%0d exp 0001 40 1", grant, load_addr, cyc);
    end
    sLoad_hit = 1'b1; load_data = 64'h77;
    sb.push_back('{4'b0001, 64'h77});
    tick();
    sLoad_hit = 1'b0;
    checks++;
    if (sb.size() == 0) begin
      failures++; $display("FAIL post_reset_rsp: scoreboard empty");
    end else begin
      e = sb.pop_front();
      if ({rsp_valid, rsp_data} !== {e.bank, e.data}) begin
        failures++;
        $display("FAIL post_reset_rsp: got=%b/%h exp=%b/%h", rsp_valid, rsp_data, e.bank, e.data);
      end
    end
    req_valid = 4'b1000;
    wait_grant(20, cyc);
    checks++;
    if ({grant, load_addr} !== {4'b1000, 32'h400}) begin
      failures++;
      $display("FAIL post_reset_next: grant=%b addr=%h exp 1000 400", grant, load_addr);
    end
    sLoad_hit = 1'b1;
    tick();
    sLoad_hit = 1'b0;
    req_valid = '0;
    tick();
  endtask

`ifdef SLOAD_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    do_reset();
    req_valid = 4'b0001;
    req_addr[0 +: 32] = 32'h500;
    wait_grant(20, cyc);
    n = 0;
    while (sLoad === 1'b1 && n < 100) begin
      n++;
      tick();
    end
    checks++;
    if (n !== 16) begin
      failures++; $display("FAIL to_len: sLoad cycles=%0d exp=16", n);
    end
    sb.push_back('{4'b0001, 64'h0});
    checks++;
    if (sb.size() == 0) begin
      failures++; $display("FAIL to_rsp: scoreboard empty");
    end else begin
      e = sb.pop_front();
      if ({rsp_valid, rsp_data, timeout_err} !== {e.bank, e.data, 1'b1}) begin
        failures++;
        $display("FAIL to_rsp: got=%b/%h/%b exp=%b/%h/1", rsp_valid, rsp_data, timeout_err, e.bank, e.data);
      end
    end
    req_valid = '0;
    tick();
    checks++;
    if ({timeout_err, busy} !== 2'b00) begin
      failures++; $display("FAIL to_pulse: timeout_err=%b busy=%b exp 0 0", timeout_err, busy);
    end
    req_valid = 4'b0001;
    wait_grant(20, cyc);
    repeat (15) tick();
    checks++;
    if (sLoad !== 1'b1) begin
      failures++; $display("FAIL to_edge_busy: sLoad=%b exp 1", sLoad);
    end
    sLoad_hit = 1'b1; load_data = 64'hF00D;
    sb.push_back('{4'b0001, 64'hF00D});
    tick();
    sLoad_hit = 1'b0;
    checks++;
    if (sb.size() == 0) begin
      failures++; $display("FAIL to_hit_wins: scoreboard empty");
    end else begin
      e = sb.pop_front();
      if ({rsp_valid, rsp_data, timeout_err} !== {e.bank, e.data, 1'b0}) begin
        failures++;
        $display("FAIL to_hit_wins: got=%b/%h/%b exp=%b/%h/0", rsp_valid, rsp_data, timeout_err, e.bank, e.data);
      end
    end
    req_valid = '0;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_back_to_back();
    test_ignore();
    test_async_reset();
`ifdef SLOAD_ARB_TIMEOUT_EN
    test_timeout();
`endif
    checks++;
    if (sb.size() !== 0) begin
      failures++; $display("FAIL sb_drain: %0d responses never seen", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
